mult_sequencer: RTL
===================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter OPW, default 8, meaning operand width in sign-magnitude form (bit OPW-1 = sign).
REQ-002 SHALL have parameter STEPS, default OPW-1 (7), meaning the maximum shift-add iterations per operation.
REQ-003 SHALL have a single clock; reset is synchronous and active-low.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 req0 / req1  in  1 each  request from requester 0 / 1, held high until that requester's done.
REQ-007 a0, b0 / a1, b1  in  OPW each  multiplier and multiplicand of requester 0 / 1.
REQ-008 ack0 / ack1  out  1 each  one-cycle grant pulse; operands are captured in this cycle.
REQ-009 done0 / done1  out  1 each  one-cycle completion pulse.
REQ-010 result  out  2*(OPW-1) (14)  product magnitude, held until the next completion.
REQ-011 sign  out  1  product sign, held with result.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 dp_load  out  1  datapath load strobe.
REQ-014 dp_step  out  1  datapath single shift/add step strobe.
REQ-015 dp_multiplier / dp_multiplicand  out  OPW-1 each  latched operand magnitudes.
REQ-016 dp_zero  in  1  datapath flag: remaining multiplier bits all zero.
REQ-017 dp_product  in  2*(OPW-1)  datapath accumulator.

Function
REQ-018 FSM states: IDLE, LOAD, RUN, FIN; all outputs are Moore, decoded from registered state and registers.
REQ-019 IDLE: if either req is high, grant exactly one, pulse its ack, latch its operand magnitudes and sign = a[OPW-1]^b[OPW-1], record the grant owner, go to LOAD.
REQ-020 Arbitration: single request wins; with both high, the requester not granted last wins (round-robin); last-grant resets to 1 so req0 wins the first tie.
REQ-021 LOAD: dp_load=1 for exactly one cycle; step counter cleared; go to RUN.
REQ-022 RUN: if dp_zero=1 or counter=STEPS, go to FIN with dp_step=0; else dp_step=1 and counter+1.
REQ-023 FIN: result <= dp_product; sign <= latched sign AND (dp_product!=0), so zero is never negative; pulse done of the owner; go to IDLE.
REQ-024 Latency ack-to-done = 3 + k cycles, where k = number of dp_step pulses (0..STEPS); the maximum is 10 for OPW=8.
REQ-025 Requests arriving or dropping while busy are ignored until IDLE; no request is granted in the FIN cycle.
REQ-026 Back-to-back: a request already high when FIN returns to IDLE is granted in that IDLE cycle (one idle cycle between operations).
REQ-027 Magnitude of operands is bits OPW-2:0 verbatim (sign-magnitude, no two's complement); the operand encoding with magnitude 0 and sign 1 is treated as zero.
REQ-028 ack, done, dp_load and dp_step are never high simultaneously; at most one ackX and one doneX are high in any cycle.

Reset
REQ-029 reset_n=0 at a rising edge SHALL force IDLE, counter=0, last-grant=1, result=0, sign=0, latched operands=0; all pulse outputs and busy are 0 in the following cycle.
REQ-030 Reset mid-operation SHALL abort without done; the datapath receives no further dp_load or dp_step strobes.

Structure
REQ-031 Package mult_seq_pkg SHALL hold the state enum, OPW/STEPS defaults, and the derived product width 2*(OPW-1).
REQ-032 Round-robin two-way grant logic SHALL be the sub-module rr_arbiter2 (req[1:0], last, gnt[1:0]); the counter and FSM stay in mult_sequencer.

Verification (bench uses a behavioural shift-add datapath model)
REQ-033 req0, a0=0x05, b0=0x03 -> ack0 at T, dp_load at T+1, 3 dp_step, done0 at T+6, result=15, sign=0.
REQ-034 req1, a1=0x85, b1=0x03 -> result=15, sign=1; a1=0x80, b1=0x83 -> k=0, done1 at T+3, result=0, sign=0.
REQ-035 a0=0x7F, b0=0x7F -> 7 steps, done0 at T+10, result=16129 (0x3F01), sign=0.
REQ-036 req0 and req1 high together from reset -> req0 served first, req1 acked in the IDLE cycle right after done0; the next tie is granted to req0.
REQ-037 reset_n low during RUN -> no done pulse, busy=0, result=0 next cycle; a new req0 then completes normally.
REQ-038 Drop req1 while busy serving req0 -> no ack1 issued; result remains stable between done pulses.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and default sizing for the sign-magnitude multiply sequencer.
package mult_seq_pkg;

    function automatic int unsigned prod_width(input int unsigned opw);
        return 2 * (opw - 1);
    endfunction

    localparam int unsigned OPW_DEFAULT   = 8;
    localparam int unsigned STEPS_DEFAULT = OPW_DEFAULT - 1;
    localparam int unsigned PW_DEFAULT    = prod_width(OPW_DEFAULT);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StFin
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; `last` is the index of the most recent winner.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mult_sequencer.sv
// Control sequencer for a two-requester shift-add multiplier datapath.
// Operands are sign-magnitude; the datapath only ever sees magnitudes.
module mult_sequencer
    import mult_seq_pkg::*;
#(
    parameter int unsigned OPW   = OPW_DEFAULT,
    parameter int unsigned STEPS = OPW - 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [OPW-1:0]         a0,
    input  logic [OPW-1:0]         b0,
    input  logic [OPW-1:0]         a1,
    input  logic [OPW-1:0]         b1,
    output logic                   ack0,
    output logic                   ack1,
    output logic                   done0,
    output logic                   done1,
    output logic [2*(OPW-1)-1:0]   result,
    output logic                   sign,
    output logic                   busy,
    output logic                   dp_load,
    output logic                   dp_step,
    output logic [OPW-2:0]         dp_multiplier,
    output logic [OPW-2:0]         dp_multiplicand,
    input  logic                   dp_zero,
    input  logic [2*(OPW-1)-1:0]   dp_product
);

    localparam int unsigned MW = OPW - 1;
    localparam int unsigned PW = prod_width(OPW);
    localparam int unsigned CW = (STEPS < 1) ? 1 : $clog2(STEPS + 1);

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic           last_q;
    logic           owner_q;
    logic           sign_l_q;
    logic [MW-1:0]  mplier_q;
    logic [MW-1:0]  mcand_q;
    logic [PW-1:0]  result_q;
    logic           sign_q;

    logic [1:0]     gnt;
    logic [OPW-1:0] sel_a;
    logic [OPW-1:0] sel_b;
    logic           run_exit;

    rr_arbiter2 u_arb (
        .req  ({req1, req0}),
        .last (last_q),
        .gnt  (gnt)
    );

    always_comb begin
        sel_a = a0;
        sel_b = b0;
        if (gnt[1]) begin
            sel_a = a1;
            sel_b = b1;
        end
    end

    assign run_exit = dp_zero || (cnt_q == CW'(STEPS));

    // Strobes are masked while reset is asserted so an aborted operation
    // never leaks a final step or completion into the datapath or requesters.
    assign ack0    = reset_n && (state_q == StIdle) && gnt[0];
    assign ack1    = reset_n && (state_q == StIdle) && gnt[1];
    assign dp_load = reset_n && (state_q == StLoad);
    assign dp_step = reset_n && (state_q == StRun) && !run_exit;
    assign done0   = reset_n && (state_q == StFin) && !owner_q;
    assign done1   = reset_n && (state_q == StFin) && owner_q;
    assign busy    = (state_q != StIdle);

    assign result          = result_q;
    assign sign            = sign_q;
    assign dp_multiplier   = mplier_q;
    assign dp_multiplicand = mcand_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            sign_l_q <= 1'b0;
            mplier_q <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|gnt) begin
                        owner_q  <= gnt[1];
                        last_q   <= gnt[1];
                        mplier_q <= sel_a[MW-1:0];
                        mcand_q  <= sel_b[MW-1:0];
                        sign_l_q <= sel_a[OPW-1] ^ sel_b[OPW-1];
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    cnt_q   <= '0;
                    state_q <= StRun;
                end
                StRun: begin
                    if (run_exit) begin
                        // Capture here so result/sign are valid alongside done.
                        result_q <= dp_product;
                        sign_q   <= sign_l_q & (|dp_product);
                        state_q  <= StFin;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert ($onehot0({ack0, ack1, done0, done1, dp_load, dp_step}));
        end
    end

endmodule
